// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, field indices and FSM states for the FP normalize/round stage.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int MW = FRAC_W + 5;
  localparam int IEW = EXP_W + 2;
  localparam int EXP_MAX = 255;
  localparam int BIAS = 127;
  localparam int C_IDX = MW - 1;
  localparam int H_IDX = MW - 2;
  localparam int G_IDX = 2;
  localparam int R_IDX = 1;
  localparam int S_IDX = 0;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;
endpackage

// File: rtl/fp_normalize_round_if.sv
// fp_normalize_round_if: valid/ready input and output channels of the normalize/round stage.
interface fp_normalize_round_if;
  import fp_pkg::*;
  logic in_valid;
  logic in_ready;
  logic in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MW-1:0] in_mant;
  logic out_valid;
  logic out_ready;
  logic [EXP_W+FRAC_W:0] out_result;
  logic out_overflow;
  logic out_inexact;
  modport master (output in_valid, in_sign, in_exp, in_mant, out_ready,
                  input in_ready, out_valid, out_result, out_overflow, out_inexact);
  modport slave (input in_valid, in_sign, in_exp, in_mant, out_ready,
                 output in_ready, out_valid, out_result, out_overflow, out_inexact);
endinterface

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even of a normalized mantissa and exponent/infinity packing.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [IEW-1:0]    exp_i,
  input  logic [MW-2:0]     mant_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [FRAC_W-1:0] frac_o,
  output logic              overflow,
  output logic              inexact
);
  logic round_up;
  logic [FRAC_W+1:0] sig;
  logic [IEW-1:0] exp_r;
  always_comb begin
    round_up = mant_i[G_IDX] & (mant_i[R_IDX] | mant_i[S_IDX] | mant_i[3]);
    inexact = |mant_i[G_IDX:S_IDX];
    sig = {1'b0, mant_i[H_IDX:3]} + (FRAC_W+2)'(round_up);
    // A denormal has exp_i==1 with no hidden bit; rounding into hidden makes that field 1.
    exp_r = sig[FRAC_W+1] ? exp_i + 1'b1 : (sig[FRAC_W] ? exp_i : '0);
    overflow = exp_r >= IEW'(EXP_MAX);
    exp_o = overflow ? '1 : exp_r[EXP_W-1:0];
    frac_o = (overflow | sig[FRAC_W+1]) ? '0 : sig[FRAC_W-1:0];
  end
endmodule

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: iterative left-shift normalization, RNE rounding and IEEE single packing.
module fp_normalize_round
  import fp_pkg::*;
(
  input logic clk,
  input logic rst,
  fp_normalize_round_if.slave bus
);
  state_e state_q, state_d;
  logic sign_q, sign_d;
  logic [IEW-1:0] exp_q, exp_d;
  logic [MW-1:0] mant_q, mant_d, sh;
  logic shift;
  logic in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d;
  logic [EXP_W+FRAC_W:0] out_result_q, out_result_d;
  logic out_overflow_q, out_overflow_d;
  logic out_inexact_q, out_inexact_d;
  logic [EXP_W-1:0] r_exp;
  logic [FRAC_W-1:0] r_frac;
  logic r_ovf, r_inx;
  fp_round_rne u_round (
    .exp_i(exp_q), .mant_i(mant_q[MW-2:0]),
    .exp_o(r_exp), .frac_o(r_frac), .overflow(r_ovf), .inexact(r_inx)
  );
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    exp_d = exp_q;
    mant_d = mant_q;
    in_ready_d = in_ready_q;
    out_valid_d = out_valid_q;
    out_result_d = out_result_q;
    out_overflow_d = out_overflow_q;
    out_inexact_d = out_inexact_q;
    // At exp==1 no further shift is possible; the value is kept as a denormal.
    shift = exp_q != IEW'(1);
    sh = shift ? mant_q << 1 : mant_q;
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        sign_d = bus.in_sign;
        exp_d = {2'b00, bus.in_exp};
        mant_d = bus.in_mant;
        in_ready_d = 1'b0;
        if (bus.in_mant == '0) begin
          state_d = DONE;
          out_valid_d = 1'b1;
          out_result_d = '0;
        end else if (bus.in_mant[C_IDX]) begin
          mant_d = {1'b0, bus.in_mant[MW-1:2], |bus.in_mant[1:0]};
          exp_d = {2'b00, bus.in_exp} + 1'b1;
          state_d = ROUND;
        end else begin
          state_d = bus.in_mant[H_IDX] ? ROUND : SHIFT;
        end
      end
      SHIFT: begin
        mant_d = sh;
        exp_d = shift ? exp_q - 1'b1 : exp_q;
        state_d = (sh[H_IDX] || exp_d == IEW'(1)) ? ROUND : SHIFT;
      end
      ROUND: begin
        out_result_d = {sign_q, r_exp, r_frac};
        out_overflow_d = r_ovf;
        out_inexact_d = r_inx;
        out_valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) begin
        state_d = IDLE;
        in_ready_d = 1'b1;
        out_valid_d = 1'b0;
        out_result_d = '0;
        out_overflow_d = 1'b0;
        out_inexact_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      exp_q <= '0;
      mant_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_result_q <= '0;
      out_overflow_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      mant_q <= mant_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_result_q <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_inexact_q <= out_inexact_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_inexact = out_inexact_q;
endmodule
